sram_2rw_rr_arbiter: RTL and testbench
======================================

// Module: sram_2rw_rr_arbiter
// PURPOSE
//   Shares the two RW ports of the wrapped 64x8 dual-port SRAM among NREQ requesters.
//   Each cycle a round-robin scheduler grants up to two requests: the first winner goes
//   to port 0 and the second to port 1. The block also filters address hazards and
//   returns read data to the requester that issued the read.
//   It sits between client logic and wrap_saed32_64x8 and drives that wrapper's
//   A/D/WE/WEM/CE pins directly.
// PARAMETERS
//   NREQ  4  number of requesters (2..8)
//   AW    6  address width (fixed by 64-word macro)
//   DW    8  data width (fixed by x8 macro)
// PORTS
//   CLK        in   1         clock; shared with SRAM wrapper
//   RST        in   1         synchronous reset, active-high
//   req_valid  in   NREQ      per-requester request valid
//   req_we     in   NREQ      1 = write, 0 = read
//   req_addr   in   NREQ*AW   packed addresses, requester i at [i*AW +: AW]
//   req_wdata  in   NREQ*DW   packed write data
//   req_wmask  in   NREQ*DW   packed per-bit write mask (1 = write bit)
//   req_ready  out  NREQ      request accepted this cycle (valid&ready = grant)
//   rsp_valid  out  NREQ      read data valid for requester i
//   rsp_data   out  DW        read data for the single requester with rsp_valid set
//   rsp_data2  out  DW        second read data when two reads complete in the same cycle
//   rsp_sel2   out  NREQ      one-hot owner of rsp_data2
//   A0,A1      out  AW        SRAM port addresses
//   D0,D1      out  DW        SRAM write data
//   WEM0,WEM1  out  DW        SRAM write masks
//   WE0,WE1    out  1         SRAM write enables, active-high
//   CE0,CE1    out  1         SRAM port enables, active-high
//   Q0,Q1      in   DW        SRAM read data, valid the cycle after the access
//   conflict_cnt out 16       saturating count of hazard-deferred requests
// BEHAVIOUR
//   Reset (RST=1 at posedge):
//     - req_ready=0, rsp_valid=0, rsp_sel2=0, CE0=CE1=0, WE0=WE1=0, conflict_cnt=0.
//     - Round-robin pointer rr_ptr=0; pending response tags cleared.
//     - While RST is high, outputs are forced to these values combinationally.
//   Grant (combinational, cycle N):
//     - Scan req_valid from rr_ptr upward with modulo-NREQ wrap.
//     - First valid requester -> winner W0 on port 0. Next valid requester -> candidate W1.
//     - W1 is granted on port 1 unless addr(W1)==addr(W0) and (we(W0)|we(W1)).
//       Two reads of the same address are allowed.
//     - A hazard-blocked W1 is not replaced by a later requester; port 1 idles.
//       conflict_cnt increments by 1 and saturates at 16'hFFFF.
//     - req_ready[i]=1 only for granted requesters.
//     - CEx=1 for each granted port. WEx=we, Ax/Dx/WEMx come from the owner.
//     - An idle port drives CEx=0, WEx=0 and zeros on A/D/WEM.
//   Pointer update at posedge N:
//     - If any grant, rr_ptr <= (index of last granted requester + 1) mod NREQ.
//     - If no grant, rr_ptr is unchanged.
//   Read response:
//     - A read granted in cycle N produces rsp_valid for that requester in cycle N+1.
//     - The owner tag and a port-valid bit are registered at posedge N, so latency is 1 cycle.
//     - Single read: rsp_data=Q of its port, rsp_valid[owner]=1.
//     - Two reads: the port-0 owner receives rsp_data; the port-1 owner receives rsp_data2
//       with rsp_sel2 one-hot. rsp_valid has both bits set.
//     - Writes produce no response. rsp_data and rsp_data2 are 0 when unused.
//   Requesters may change or drop req_valid freely; there is no hold requirement.
//   A request with valid&~ready must be retried by the client.
//   RST asserted mid-operation drops any pending response (rsp_valid=0 next cycle).
//   SRAM contents are not cleared by reset.
// TESTING
//   1. Reset: hold RST 3 cycles with all req_valid=1 -> req_ready=0, CE0=CE1=0,
//      rsp_valid=0, conflict_cnt=0.
//   2. Two clients: req0 writes addr 5 data 8'hA5 mask FF; req2 writes addr 9 data 8'h3C
//      in the same cycle -> both ready, port0=req0, port1=req2. Reads of 5 and 9 in the
//      same cycle return A5 on rsp_data to the port-0 owner and 3C on rsp_data2 to the
//      port-1 owner, one cycle later.
//   3. Hazard: req1 writes addr 7 while req2 reads addr 7 (rr_ptr=0) -> only req1 granted,
//      CE1=0, conflict_cnt=1. Next cycle req2 is granted and reads the new data.
//   4. Fairness: all 4 requesters hold reads to distinct addresses for 6 cycles ->
//      grant pairs {0,1},{2,3},{0,1},...; each requester gets 3 grants.
//   5. Masked write: write FF to addr 3, then write 00 with mask 0F ->
//      a later read of addr 3 returns F0.
//   6. Reset mid-read: grant a read, assert RST next cycle -> rsp_valid stays 0 and
//      rr_ptr returns to 0.

Source files
------------

// File: rtl/sram_2rw_rr_arbiter.sv
// rtl/sram_2rw_rr_arbiter.sv - round-robin arbiter sharing a 2-port 64x8 SRAM among NREQ requesters
module sram_2rw_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 6,
  parameter int DW   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ*DW-1:0]   req_wmask,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic [DW-1:0]        rsp_data2,
  output logic [NREQ-1:0]      rsp_sel2,
  output logic [AW-1:0]        A0,
  output logic [AW-1:0]        A1,
  output logic [DW-1:0]        D0,
  output logic [DW-1:0]        D1,
  output logic [DW-1:0]        WEM0,
  output logic [DW-1:0]        WEM1,
  output logic                 WE0,
  output logic                 WE1,
  output logic                 CE0,
  output logic                 CE1,
  input  logic [DW-1:0]        Q0,
  input  logic [DW-1:0]        Q1,
  output logic [15:0]          conflict_cnt
);

  localparam int IW = (NREQ > 2) ? $clog2(NREQ) : 1;

  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic          rd0_q, rd0_d, rd1_q, rd1_d;
  logic [IW-1:0] tag0_q, tag0_d, tag1_q, tag1_d;
  logic [15:0]   conflict_cnt_q, conflict_cnt_d;

  logic          w0_found, w1_found;
  logic [IW-1:0] w0_idx, w1_idx;
  logic [IW:0]   scan_sum;
  logic [IW-1:0] scan_idx;
  logic          hazard, grant0, grant1;
  logic [AW-1:0] w0_addr, w1_addr;
  logic          w0_we, w1_we;

  // Scan requesters starting at the round-robin pointer, picking the first two valid ones
  always_comb begin
    w0_found = 1'b0;
    w1_found = 1'b0;
    w0_idx   = '0;
    w1_idx   = '0;
    scan_sum = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (IW+1)'(k);
      if (scan_sum >= (IW+1)'(NREQ)) begin
        scan_sum = scan_sum - (IW+1)'(NREQ);
      end
      scan_idx = scan_sum[IW-1:0];
      if (req_valid[scan_idx]) begin
        if (!w0_found) begin
          w0_found = 1'b1;
          w0_idx   = scan_idx;
        end else if (!w1_found) begin
          w1_found = 1'b1;
          w1_idx   = scan_idx;
        end
      end
    end
  end

  // Hazard filter: the second winner idles its port when it collides with a write on the same address
  always_comb begin
    w0_addr = req_addr[w0_idx*AW +: AW];
    w1_addr = req_addr[w1_idx*AW +: AW];
    w0_we   = req_we[w0_idx];
    w1_we   = req_we[w1_idx];
    hazard  = !RST && w0_found && w1_found && (w0_addr == w1_addr) && (w0_we || w1_we);
    grant0  = !RST && w0_found;
    grant1  = !RST && w1_found && !hazard;
  end

  // Drive the SRAM pins and ready flags from the port owners; idle ports drive zeros
  always_comb begin
    req_ready = '0;
    A0 = '0; D0 = '0; WEM0 = '0; WE0 = 1'b0; CE0 = 1'b0;
    A1 = '0; D1 = '0; WEM1 = '0; WE1 = 1'b0; CE1 = 1'b0;
    if (grant0) begin
      req_ready[w0_idx] = 1'b1;
      CE0  = 1'b1;
      WE0  = w0_we;
      A0   = w0_addr;
      D0   = req_wdata[w0_idx*DW +: DW];
      WEM0 = req_wmask[w0_idx*DW +: DW];
    end
    if (grant1) begin
      req_ready[w1_idx] = 1'b1;
      CE1  = 1'b1;
      WE1  = w1_we;
      A1   = w1_addr;
      D1   = req_wdata[w1_idx*DW +: DW];
      WEM1 = req_wmask[w1_idx*DW +: DW];
    end
  end

  // Next pointer, pending read tags and saturating conflict counter
  always_comb begin
    rr_ptr_d       = rr_ptr_q;
    rd0_d          = grant0 && !w0_we;
    rd1_d          = grant1 && !w1_we;
    tag0_d         = w0_idx;
    tag1_d         = w1_idx;
    conflict_cnt_d = conflict_cnt_q;
    if (grant1) begin
      rr_ptr_d = (w1_idx == IW'(NREQ-1)) ? '0 : w1_idx + 1'b1;
    end else if (grant0) begin
      rr_ptr_d = (w0_idx == IW'(NREQ-1)) ? '0 : w0_idx + 1'b1;
    end
    if (hazard && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      rr_ptr_q       <= '0;
      rd0_q          <= 1'b0;
      rd1_q          <= 1'b0;
      tag0_q         <= '0;
      tag1_q         <= '0;
      conflict_cnt_q <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      rd0_q          <= rd0_d;
      rd1_q          <= rd1_d;
      tag0_q         <= tag0_d;
      tag1_q         <= tag1_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  // Route last cycle's read data back to its owners; a lone port-1 read still uses rsp_data
  always_comb begin
    rsp_valid    = '0;
    rsp_data     = '0;
    rsp_data2    = '0;
    rsp_sel2     = '0;
    conflict_cnt = RST ? 16'h0000 : conflict_cnt_q;
    if (!RST) begin
      if (rd0_q && rd1_q) begin
        rsp_valid[tag0_q] = 1'b1;
        rsp_valid[tag1_q] = 1'b1;
        rsp_data          = Q0;
        rsp_data2         = Q1;
        rsp_sel2[tag1_q]  = 1'b1;
      end else if (rd0_q) begin
        rsp_valid[tag0_q] = 1'b1;
        rsp_data          = Q0;
      end else if (rd1_q) begin
        rsp_valid[tag1_q] = 1'b1;
        rsp_data          = Q1;
      end
    end
  end

endmodule

// File: tb/tb_sram_2rw_rr_arbiter.sv
// tb/tb_sram_2rw_rr_arbiter.sv - directed bench for sram_2rw_rr_arbiter with a behavioural SRAM
module tb_sram_2rw_rr_arbiter;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  req_valid, req_we, req_ready, rsp_valid, rsp_sel2;
  logic [23:0] req_addr;
  logic [31:0] req_wdata, req_wmask;
  logic [7:0]  rsp_data, rsp_data2;
  logic [5:0]  A0, A1;
  logic [7:0]  D0, D1, WEM0, WEM1, Q0, Q1;
  logic        WE0, WE1, CE0, CE1;
  logic [15:0] conflict_cnt;

  logic [7:0]  mem [0:63];
  int          total = 0;
  int          bad = 0;
  int          gcnt [0:3];

  sram_2rw_rr_arbiter #(.NREQ(4), .AW(6), .DW(8)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wmask(req_wmask), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_data2(rsp_data2), .rsp_sel2(rsp_sel2),
    .A0(A0), .A1(A1), .D0(D0), .D1(D1), .WEM0(WEM0), .WEM1(WEM1),
    .WE0(WE0), .WE1(WE1), .CE0(CE0), .CE1(CE1), .Q0(Q0), .Q1(Q1),
    .conflict_cnt(conflict_cnt)
  );

  always #5 CLK = ~CLK;

  // Behavioural 64x8 dual-port SRAM: masked write, read data one cycle after access
  always @(posedge CLK) begin
    if (CE0) begin
      if (WE0) mem[A0] <= (mem[A0] & ~WEM0) | (D0 & WEM0);
      else     Q0 <= mem[A0];
    end
    if (CE1) begin
      if (WE1) mem[A1] <= (mem[A1] & ~WEM1) | (D1 & WEM1);
      else     Q1 <= mem[A1];
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic clr();
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_wmask = '0;
  endtask

  task automatic set_req(input int i, input logic we, input logic [5:0] a,
                         input logic [7:0] d, input logic [7:0] m);
    req_valid[i]       = 1'b1;
    req_we[i]          = we;
    req_addr[i*6 +: 6] = a;
    req_wdata[i*8 +: 8] = d;
    req_wmask[i*8 +: 8] = m;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    Q0 = 8'h00;
    Q1 = 8'h00;
    clr();
    RST = 1'b1;

    // Reset with every requester asking
    for (int i = 0; i < 4; i++) set_req(i, 1'b0, 6'(i), 8'h00, 8'h00);
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      chk("rst_ready", 32'(req_ready), 32'h0);
      chk("rst_ce", 32'({CE0, CE1}), 32'h0);
      chk("rst_rspv", 32'(rsp_valid), 32'h0);
      chk("rst_cnt", 32'(conflict_cnt), 32'h0);
      cyc();
    end
    RST = 1'b0;

    // Two writers, then two readers of the same addresses
    clr();
    set_req(0, 1'b1, 6'd5, 8'hA5, 8'hFF);
    set_req(2, 1'b1, 6'd9, 8'h3C, 8'hFF);
    @(negedge CLK);
    chk("wr2_ready", 32'(req_ready), 32'h5);
    chk("wr2_ce", 32'({CE0, CE1, WE0, WE1}), 32'hF);
    chk("wr2_a0", 32'(A0), 32'd5);
    chk("wr2_a1", 32'(A1), 32'd9);
    chk("wr2_d", 32'({D0, D1}), 32'hA53C);
    cyc();
    clr();
    set_req(0, 1'b0, 6'd5, 8'h00, 8'h00);
    set_req(2, 1'b0, 6'd9, 8'h00, 8'h00);
    @(negedge CLK);
    chk("rd2_ready", 32'(req_ready), 32'h5);
    chk("rd2_nowrrsp", 32'(rsp_valid), 32'h0);
    cyc();
    clr();
    @(negedge CLK);
    chk("rd2_rspv", 32'(rsp_valid), 32'h5);
    chk("rd2_data", 32'(rsp_data), 32'hA5);
    chk("rd2_data2", 32'(rsp_data2), 32'h3C);
    chk("rd2_sel2", 32'(rsp_sel2), 32'h4);
    cyc();

    // Hazard: write and read of the same address with rr_ptr back at 0
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    set_req(1, 1'b1, 6'd7, 8'h5A, 8'hFF);
    set_req(2, 1'b0, 6'd7, 8'h00, 8'h00);
    @(negedge CLK);
    chk("hz_ready", 32'(req_ready), 32'h2);
    chk("hz_ce", 32'({CE0, CE1}), 32'h2);
    chk("hz_a0", 32'(A0), 32'd7);
    cyc();
    clr();
    set_req(2, 1'b0, 6'd7, 8'h00, 8'h00);
    @(negedge CLK);
    chk("hz_cnt", 32'(conflict_cnt), 32'd1);
    chk("hz_retry_ready", 32'(req_ready), 32'h4);
    cyc();
    clr();
    @(negedge CLK);
    chk("hz_rspv", 32'(rsp_valid), 32'h4);
    chk("hz_data", 32'(rsp_data), 32'h5A);
    chk("hz_sel2", 32'(rsp_sel2), 32'h0);
    chk("hz_cnt_hold", 32'(conflict_cnt), 32'd1);
    cyc();

    // Fairness: all four requesters read distinct addresses for six cycles
    RST = 1'b1;
    cyc();
    RST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      gcnt[i] = 0;
      set_req(i, 1'b0, 6'(20 + i), 8'h00, 8'h00);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      chk($sformatf("fair_ready%0d", c), 32'(req_ready), (c % 2 == 0) ? 32'h3 : 32'hC);
      if (c > 0) chk($sformatf("fair_rspv%0d", c), 32'(rsp_valid), (c % 2 == 0) ? 32'hC : 32'h3);
      for (int i = 0; i < 4; i++) if (req_ready[i]) gcnt[i]++;
      cyc();
    end
    clr();
    @(negedge CLK);
    chk("fair_rspv_last", 32'(rsp_valid), 32'hC);
    for (int i = 0; i < 4; i++) chk($sformatf("fair_cnt%0d", i), 32'(gcnt[i]), 32'd3);
    cyc();

    // Masked write: FF then 00 under mask 0F leaves F0
    set_req(0, 1'b1, 6'd3, 8'hFF, 8'hFF);
    cyc();
    set_req(0, 1'b1, 6'd3, 8'h00, 8'h0F);
    @(negedge CLK);
    chk("mw_wem0", 32'(WEM0), 32'h0F);
    cyc();
    set_req(0, 1'b0, 6'd3, 8'h00, 8'h00);
    cyc();
    clr();
    @(negedge CLK);
    chk("mw_rspv", 32'(rsp_valid), 32'h1);
    chk("mw_data", 32'(rsp_data), 32'hF0);
    cyc();

    // Reset right after a granted read drops the response and rewinds the pointer
    set_req(1, 1'b0, 6'd12, 8'h00, 8'h00);
    @(negedge CLK);
    chk("mr_ready", 32'(req_ready), 32'h2);
    cyc();
    clr();
    RST = 1'b1;
    @(negedge CLK);
    chk("mr_rspv_rst", 32'(rsp_valid), 32'h0);
    cyc();
    RST = 1'b0;
    set_req(0, 1'b0, 6'd10, 8'h00, 8'h00);
    set_req(3, 1'b0, 6'd11, 8'h00, 8'h00);
    @(negedge CLK);
    chk("mr_rspv_after", 32'(rsp_valid), 32'h0);
    chk("mr_ptr_a0", 32'(A0), 32'd10);
    chk("mr_ptr_a1", 32'(A1), 32'd11);
    chk("mr_ready2", 32'(req_ready), 32'h9);
    cyc();
    clr();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
